fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Producer of the 2-bit select codes that drive the 4:1 operand muxes in the EX stage of the pipelined datapath.
- Internally pipelines destination-register and write-enable info from decode through E, M and W.
- Resolves operand forwarding between pipeline stages.
- Generates stall and flush controls for load-use hazards and for the busy window of the multicycle multiply/divide unit.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- MD_LATENCY, 32, cycles the multiply/divide unit stays busy after a start; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge of clk.
- rs_d  input  REG_ADDR_W  decode-stage source register A.
- rt_d  input  REG_ADDR_W  decode-stage source register B.
- uses_rt_d  input  1  decoded instruction reads rt.
- dst_d  input  REG_ADDR_W  decode-stage destination register (already muxed rt/rd).
- regwrite_d  input  1  decoded instruction writes the register file.
- memtoreg_d  input  1  decoded instruction is a load.
- md_start_d  input  1  decoded instruction starts a multiply/divide.
- md_use_d  input  1  decoded instruction reads HI/LO.
- fwd_a_e  output  2  EX mux select, operand A.
- fwd_b_e  output  2  EX mux select, operand B.
- stall_f  output  1  hold PC.
- stall_d  output  1  hold IF/ID register.
- flush_e  output  1  insert bubble into ID/EX.
- md_busy  output  1  multiply/divide counter nonzero.
- fwd_a_d  output  1  branch-compare forward from M, operand A (FWD_BRANCH_EN).
- fwd_b_d  output  1  branch-compare forward from M, operand B (FWD_BRANCH_EN).

Behaviour:
- Select encoding:
  - 00 = register-file value.
  - 01 = WB result.
  - 10 = MEM ALU result.
  - 11 = reserved, never driven.
- Internal stage registers:
  - E stage: rs_e, rt_e, dst_e, regwrite_e, memtoreg_e.
  - M stage: dst_m, regwrite_m.
  - W stage: dst_w, regwrite_w.
  - All advance every clk.
  - E captures the *_d inputs unless flush_e=1. On flush_e=1 it captures zeros, i.e. a bubble.
- Forward rule for operand A (same rule for B using rt_e):
  - fwd_a_e=10 if regwrite_m, dst_m!=0 and dst_m==rs_e.
  - Otherwise 01 if regwrite_w, dst_w!=0 and dst_w==rs_e.
  - Otherwise 00.
  - MEM has priority over WB.
  - Register 0 is never forwarded.
  - fwd_*_e are a function of registered state only (Moore), valid from cycle start.
- Load-use hazard:
  - lwstall = memtoreg_e & regwrite_e & dst_e!=0 & (dst_e==rs_d | (uses_rt_d & dst_e==rt_d)).
- MD counter:
  - Reset value 0.
  - On md_start_d & ~stall_d, loaded with MD_LATENCY.
  - Otherwise decrements while nonzero; saturates at 0.
  - md_busy = (cnt != 0).
- MD hazard:
  - mdstall = md_busy & (md_start_d | md_use_d).
  - A start is not accepted while stalled.
- Stall outputs:
  - stall_f = stall_d = flush_e = lwstall | mdstall (| brstall when the feature is on).
  - All are combinational from inputs plus state.
- Simultaneous lwstall and mdstall: a single stall cycle per condition; signals stay asserted until both clear.
- Counter timing: a load on the same cycle the counter reaches 1→0 is accepted, because md_busy is already 0 only when cnt==0. A start issued while cnt==1 stalls one cycle.
- Reset values:
  - All stage registers are 0 and the counter is 0.
  - While reset is deasserted after reset: fwd_*_e=00, md_busy=0.
  - stall/flush are 0 unless the decode inputs create a hazard against the cleared state; none can, because dst_e=0.
- Reset mid-operation: an in-flight MD count is abandoned, and pending forwards are discarded on the same edge.

Optional Feature:
- Macro: FWD_BRANCH_EN.
- When defined:
  - fwd_a_d = regwrite_m & dst_m!=0 & dst_m==rs_d (same rule for B with rt_d).
  - Adds input branch_d (1 bit).
  - brstall = branch_d & ((regwrite_e & dst_e!=0 & (dst_e==rs_d | dst_e==rt_d)) | (memtoreg_m & dst_m!=0 & (dst_m==rs_d | dst_m==rt_d))). This requires carrying memtoreg into M.
- When undefined:
  - fwd_*_d are tied 0.
  - branch_d is absent.
  - No brstall term.

Decomposition:
- Package fwd_pkg holds:
  - Select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, FWD_RSVD=2'b11.
  - REG0 address constant.
- Sub-module md_busy_ctr (parameter MD_LATENCY; ports clk, reset, load, busy) owns the counter.

Test Plan:
- Back-to-back ALU ops (add $3 then sub $4,$3,$5) → fwd_a_e=10 for one cycle; with one NOP between them → fwd_a_e=01.
- Both M and W write $7 and E reads $7 → fwd_a_e=10, because MEM wins.
- Writes to $0 in M and W → fwd_*_e stay 00.
- lw $2 in E, decode reads $2 → stall_f=stall_d=flush_e=1 for exactly 1 cycle; then fwd_a_e=10 is not selected and fwd_a_e=01 follows on the next op.
- MD_LATENCY=4: md_start_d then md_use_d on the next cycle → stall for 4 cycles; md_busy falls on cycle 5.
- Assert reset while cnt=3 and M holds a forwardable write → next cycle md_busy=0, fwd_*_e=00, no stall.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared constants for the EX-stage forwarding/hazard controller:
// operand-mux select codes, the hard-wired zero register and the select priority helper.
package fwd_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF   = 2'b00;
    localparam fwd_sel_t FWD_WB   = 2'b01;
    localparam fwd_sel_t FWD_MEM  = 2'b10;
    localparam fwd_sel_t FWD_RSVD = 2'b11;

    localparam int REG0 = 0;

    // MEM result is younger than WB, so it wins when both match.
    function automatic fwd_sel_t fwd_select(input logic hit_m, input logic hit_w);
        if (hit_m) begin
            return FWD_MEM;
        end
        if (hit_w) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// Busy-window counter for the multicycle multiply/divide unit: loads MD_LATENCY
// on an accepted start, then counts down to zero and holds there.
module md_busy_ctr #(
    parameter int MD_LATENCY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic busy
);

    localparam int CNT_W = 8;

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= CNT_W'(MD_LATENCY);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign busy = (r_cnt != '0);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX operand-forwarding selects plus load-use / multiply-divide stall and flush control.
// Define FWD_BRANCH_EN to add decode-stage branch-compare forwarding and branch stalls.
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LATENCY = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic                  uses_rt_d,
    input  logic [REG_ADDR_W-1:0] dst_d,
    input  logic                  regwrite_d,
    input  logic                  memtoreg_d,
    input  logic                  md_start_d,
    input  logic                  md_use_d,
`ifdef FWD_BRANCH_EN
    input  logic                  branch_d,
`endif
    output logic [1:0]            fwd_a_e,
    output logic [1:0]            fwd_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_e,
    output logic                  md_busy,
    output logic                  fwd_a_d,
    output logic                  fwd_b_d
);

    localparam logic [REG_ADDR_W-1:0] REG0_ADDR = REG_ADDR_W'(REG0);

    logic [REG_ADDR_W-1:0] r_rs_e, r_rt_e, r_dst_e, r_dst_m, r_dst_w;
    logic                  r_regwrite_e, r_memtoreg_e, r_regwrite_m, r_regwrite_w;

    logic w_hit_a_m, w_hit_a_w, w_hit_b_m, w_hit_b_w;
    logic w_lwstall, w_mdstall, w_brstall, w_stall, w_md_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs_e       <= '0;
            r_rt_e       <= '0;
            r_dst_e      <= '0;
            r_regwrite_e <= 1'b0;
            r_memtoreg_e <= 1'b0;
            r_dst_m      <= '0;
            r_regwrite_m <= 1'b0;
            r_dst_w      <= '0;
            r_regwrite_w <= 1'b0;
        end else begin
            // A stalled decode slot enters EX as an all-zero bubble.
            if (w_stall) begin
                r_rs_e       <= '0;
                r_rt_e       <= '0;
                r_dst_e      <= '0;
                r_regwrite_e <= 1'b0;
                r_memtoreg_e <= 1'b0;
            end else begin
                r_rs_e       <= rs_d;
                r_rt_e       <= rt_d;
                r_dst_e      <= dst_d;
                r_regwrite_e <= regwrite_d;
                r_memtoreg_e <= memtoreg_d;
            end
            r_dst_m      <= r_dst_e;
            r_regwrite_m <= r_regwrite_e;
            r_dst_w      <= r_dst_m;
            r_regwrite_w <= r_regwrite_m;
        end
    end

    assign w_hit_a_m = r_regwrite_m && (r_dst_m != REG0_ADDR) && (r_dst_m == r_rs_e);
    assign w_hit_a_w = r_regwrite_w && (r_dst_w != REG0_ADDR) && (r_dst_w == r_rs_e);
    assign w_hit_b_m = r_regwrite_m && (r_dst_m != REG0_ADDR) && (r_dst_m == r_rt_e);
    assign w_hit_b_w = r_regwrite_w && (r_dst_w != REG0_ADDR) && (r_dst_w == r_rt_e);

    assign fwd_a_e = fwd_select(w_hit_a_m, w_hit_a_w);
    assign fwd_b_e = fwd_select(w_hit_b_m, w_hit_b_w);

    assign w_lwstall = r_memtoreg_e && r_regwrite_e && (r_dst_e != REG0_ADDR) &&
                       ((r_dst_e == rs_d) || (uses_rt_d && (r_dst_e == rt_d)));

    assign w_mdstall = md_busy && (md_start_d || md_use_d);

`ifdef FWD_BRANCH_EN
    logic r_memtoreg_m;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_memtoreg_m <= 1'b0;
        end else begin
            r_memtoreg_m <= r_memtoreg_e;
        end
    end

    assign fwd_a_d = r_regwrite_m && (r_dst_m != REG0_ADDR) && (r_dst_m == rs_d);
    assign fwd_b_d = r_regwrite_m && (r_dst_m != REG0_ADDR) && (r_dst_m == rt_d);

    // Branch compares in decode: an ALU result still in EX, or a load still in MEM, is not yet available.
    assign w_brstall = branch_d &&
                       ((r_regwrite_e && (r_dst_e != REG0_ADDR) && ((r_dst_e == rs_d) || (r_dst_e == rt_d))) ||
                        (r_memtoreg_m && (r_dst_m != REG0_ADDR) && ((r_dst_m == rs_d) || (r_dst_m == rt_d))));
`else
    assign fwd_a_d   = 1'b0;
    assign fwd_b_d   = 1'b0;
    assign w_brstall = 1'b0;
`endif

    assign w_stall = w_lwstall || w_mdstall || w_brstall;

    assign stall_f = w_stall;
    assign stall_d = w_stall;
    assign flush_e = w_stall;

    assign w_md_load = md_start_d && !w_stall;

    md_busy_ctr #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md_busy_ctr (
        .clk  (clk),
        .reset(reset),
        .load (w_md_load),
        .busy (md_busy)
    );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed vector table for the documented scenarios,
// then random instruction streams checked against a pipeline-history model.
module tb_fwd_hazard_ctrl;
    import fwd_pkg::*;

    localparam int AW  = 5;
    localparam int LAT = 4;

    logic          clk;
    logic          reset;
    logic [AW-1:0] rs_d, rt_d, dst_d;
    logic          uses_rt_d, regwrite_d, memtoreg_d, md_start_d, md_use_d;
    logic          branch_d;
    logic [1:0]    fwd_a_e, fwd_b_e;
    logic          stall_f, stall_d, flush_e, md_busy, fwd_a_d, fwd_b_d;

    fwd_hazard_ctrl #(
        .REG_ADDR_W(AW),
        .MD_LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_d      (rs_d),
        .rt_d      (rt_d),
        .uses_rt_d (uses_rt_d),
        .dst_d     (dst_d),
        .regwrite_d(regwrite_d),
        .memtoreg_d(memtoreg_d),
        .md_start_d(md_start_d),
        .md_use_d  (md_use_d),
`ifdef FWD_BRANCH_EN
        .branch_d  (branch_d),
`endif
        .fwd_a_e   (fwd_a_e),
        .fwd_b_e   (fwd_b_e),
        .stall_f   (stall_f),
        .stall_d   (stall_d),
        .flush_e   (flush_e),
        .md_busy   (md_busy),
        .fwd_a_d   (fwd_a_d),
        .fwd_b_d   (fwd_b_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rs, rt, dst;
        logic          uses_rt, regwrite, memtoreg, md_start, md_use, branch;
    } instr_t;

    typedef struct {
        instr_t     in;
        logic       rst;
        logic [1:0] ea, eb;
        logic       st, busy;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: instructions that entered EX, newest first (E, M, W), and the first
    // cycle number at which the multiply/divide unit is free again.
    instr_t hist[$];
    int     cyc     = 0;
    int     md_free = 0;

    vec_t tbl[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic instr_t mk(input int rs, input int rt, input bit ut, input int dst,
                                  input bit rw, input bit mtr, input bit mds, input bit mdu);
        instr_t i;
        i.rs = AW'(rs); i.rt = AW'(rt); i.dst = AW'(dst);
        i.uses_rt = ut; i.regwrite = rw; i.memtoreg = mtr;
        i.md_start = mds; i.md_use = mdu; i.branch = 1'b0;
        return i;
    endfunction

    function automatic instr_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void add_vec(input instr_t i, input bit rst, input int ea, input int eb,
                                    input bit st, input bit busy);
        vec_t v;
        v.in = i; v.rst = rst; v.ea = 2'(ea); v.eb = 2'(eb); v.st = st; v.busy = busy;
        tbl.push_back(v);
    endfunction

    function automatic void model_clear();
        hist.delete();
        for (int k = 0; k < 3; k++) hist.push_back(nop());
        md_free = 0;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] src);
        if (hist[1].regwrite && hist[1].dst != 0 && hist[1].dst == src) return FWD_MEM;
        if (hist[2].regwrite && hist[2].dst != 0 && hist[2].dst == src) return FWD_WB;
        return FWD_RF;
    endfunction

    function automatic bit exp_busy();
        return cyc < md_free;
    endfunction

    function automatic bit exp_stall(input instr_t d);
        instr_t e = hist[0];
        instr_t m = hist[1];
        bit lw, md, br;
        lw = e.memtoreg && e.regwrite && e.dst != 0 && (e.dst == d.rs || (d.uses_rt && e.dst == d.rt));
        md = exp_busy() && (d.md_start || d.md_use);
        br = 1'b0;
`ifdef FWD_BRANCH_EN
        br = d.branch && ((e.regwrite && e.dst != 0 && (e.dst == d.rs || e.dst == d.rt)) ||
                          (m.memtoreg && m.dst != 0 && (m.dst == d.rs || m.dst == d.rt)));
`endif
        return lw || md || br;
    endfunction

    function automatic bit exp_fwd_d(input logic [AW-1:0] src);
`ifdef FWD_BRANCH_EN
        return hist[1].regwrite && hist[1].dst != 0 && hist[1].dst == src;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_advance(input instr_t d, input bit rst, input bit st);
        if (rst) begin
            model_clear();
        end else begin
            if (d.md_start && !st) md_free = cyc + 1 + LAT;
            hist.push_front(st ? nop() : d);
            void'(hist.pop_back());
        end
        cyc++;
    endfunction

    // Called just after a rising edge: drive, compare at the falling edge, advance the model.
    task automatic run_cycle(input instr_t d, input bit rst, input bit use_tbl, input vec_t v,
                             output bit st_out);
        logic [1:0] ea, eb;
        bit st, busy;
        reset = rst;
        rs_d = d.rs; rt_d = d.rt; dst_d = d.dst; uses_rt_d = d.uses_rt;
        regwrite_d = d.regwrite; memtoreg_d = d.memtoreg;
        md_start_d = d.md_start; md_use_d = d.md_use; branch_d = d.branch;
        @(negedge clk);
        if (use_tbl) begin
            ea = v.ea; eb = v.eb; st = v.st; busy = v.busy;
        end else begin
            ea = exp_fwd(hist[0].rs); eb = exp_fwd(hist[0].rt);
            st = exp_stall(d); busy = exp_busy();
        end
        check("fwd_a_e", 8'(fwd_a_e), 8'(ea));
        check("fwd_b_e", 8'(fwd_b_e), 8'(eb));
        check("stall_f", 8'(stall_f), 8'(st));
        check("stall_d", 8'(stall_d), 8'(st));
        check("flush_e", 8'(flush_e), 8'(st));
        check("md_busy", 8'(md_busy), 8'(busy));
        check("fwd_a_d", 8'(fwd_a_d), 8'(exp_fwd_d(d.rs)));
        check("fwd_b_d", 8'(fwd_b_d), 8'(exp_fwd_d(d.rt)));
        st_out = exp_stall(d);
        model_advance(d, rst, st_out);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t   dummy;
        instr_t cur;
        bit     st;
        bit     rst;

        model_clear();
        dummy = '{in: nop(), rst: 1'b0, ea: 2'b00, eb: 2'b00, st: 1'b0, busy: 1'b0};

        // reset state: hazard-looking decode inputs cannot stall against cleared state
        add_vec(mk(3, 3, 1, 3, 1, 1, 0, 1), 0, 0, 0, 0, 0);
        add_vec(nop(), 0, 0, 0, 0, 0);
        add_vec(nop(), 0, 0, 0, 0, 0);
        // back-to-back: add $3 ; sub $4,$3,$5
        add_vec(mk(1, 2, 1, 3, 1, 0, 0, 0), 0, 0, 0, 0, 0);
        add_vec(mk(3, 5, 1, 4, 1, 0, 0, 0), 0, 0, 0, 0, 0);
        add_vec(nop(), 0, 2, 0, 0, 0);
        add_vec(nop(), 0, 0, 0, 0, 0);
        // one NOP between producer and consumer
        add_vec(mk(1, 2, 1, 3, 1, 0, 0, 0), 0, 0, 0, 0, 0);
        add_vec(nop(), 0, 0, 0, 0, 0);
        add_vec(mk(3, 5, 1, 4, 1, 0, 0, 0), 0, 0, 0, 0, 0);
        add_vec(nop(), 0, 1, 0, 0, 0);
        // M and W both write $7: MEM wins on both operands
        add_vec(mk(1, 0, 0, 7, 1, 0, 0, 0), 0, 0, 0, 0, 0);
        add_vec(mk(1, 2, 1, 7, 1, 0, 0, 0), 0, 0, 0, 0, 0);
        add_vec(mk(7, 7, 1, 8, 1, 0, 0, 0), 0, 0, 0, 0, 0);
        add_vec(nop(), 0, 2, 2, 0, 0);
        // writes to $0 in M and W are never forwarded
        add_vec(mk(1, 2, 1, 0, 1, 0, 0, 0), 0, 0, 0, 0, 0);
        add_vec(mk(1, 2, 1, 0, 1, 0, 0, 0), 0, 0, 0, 0, 0);
        add_vec(mk(0, 0, 1, 9, 1, 0, 0, 0), 0, 0, 0, 0, 0);
        add_vec(nop(), 0, 0, 0, 0, 0);
        // load-use: lw $2 ; add $5,$2,$3 stalls once, then takes the WB path
        add_vec(mk(1, 0, 0, 2, 1, 1, 0, 0), 0, 0, 0, 0, 0);
        add_vec(mk(2, 3, 1, 5, 1, 0, 0, 0), 0, 0, 0, 1, 0);
        add_vec(mk(2, 3, 1, 5, 1, 0, 0, 0), 0, 0, 0, 0, 0);
        add_vec(nop(), 0, 1, 0, 0, 0);
        // mult then mfhi: four stall cycles, busy drops on the fifth
        add_vec(mk(4, 5, 1, 0, 0, 0, 1, 0), 0, 0, 0, 0, 0);
        add_vec(mk(0, 0, 0, 6, 1, 0, 0, 1), 0, 0, 1, 1, 1);
        add_vec(mk(0, 0, 0, 6, 1, 0, 0, 1), 0, 0, 0, 1, 1);
        add_vec(mk(0, 0, 0, 6, 1, 0, 0, 1), 0, 0, 0, 1, 1);
        add_vec(mk(0, 0, 0, 6, 1, 0, 0, 1), 0, 0, 0, 1, 1);
        add_vec(mk(0, 0, 0, 6, 1, 0, 0, 1), 0, 0, 0, 0, 0);
        add_vec(nop(), 0, 0, 0, 0, 0);
        // reset while the counter holds 3 and M holds a forwardable write
        add_vec(mk(1, 2, 1, 10, 1, 0, 1, 0), 0, 0, 0, 0, 0);
        add_vec(mk(10, 10, 1, 11, 1, 0, 0, 0), 0, 0, 0, 0, 1);
        add_vec(nop(), 1, 2, 2, 0, 1);
        add_vec(mk(10, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0, 0);

        reset = 1'b1;
        rs_d = '0; rt_d = '0; dst_d = '0; uses_rt_d = 0; regwrite_d = 0;
        memtoreg_d = 0; md_start_d = 0; md_use_d = 0; branch_d = 0;
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[k]) begin
            run_cycle(tbl[k].in, tbl[k].rst, 1'b1, tbl[k], st);
        end

        // random streams: a stalled decode slot is re-presented unchanged
        cur = nop();
        st  = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!st) begin
                cur.rs       = AW'($urandom_range(0, 7));
                cur.rt       = AW'($urandom_range(0, 7));
                cur.dst      = AW'($urandom_range(0, 7));
                cur.uses_rt  = ($urandom_range(0, 1) == 1);
                cur.regwrite = ($urandom_range(0, 3) != 0);
                cur.memtoreg = cur.regwrite && ($urandom_range(0, 2) == 0);
                cur.md_start = ($urandom_range(0, 9) == 0);
                cur.md_use   = ($urandom_range(0, 6) == 0);
`ifdef FWD_BRANCH_EN
                cur.branch   = ($urandom_range(0, 4) == 0);
`else
                cur.branch   = 1'b0;
`endif
            end
            rst = ($urandom_range(0, 59) == 0);
            run_cycle(cur, rst, 1'b0, dummy, st);
            if (rst) st = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
